pc_ctrl: RTL and testbench

PC_CTRL -- requirements
Module: pc_ctrl

---
 rtl/pc_ctrl_if.sv | 34 +++
 rtl/pc_ctrl.sv | 119 +++++++++++
 tb/tb_pc_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/pc_ctrl_if.sv
// Bundles the pipeline-side request inputs and PC/pipeline control outputs of pc_ctrl.
// The slave modport is the controller view; the master modport is the pipeline/driver view.
interface pc_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             halt;
  logic             imem_ready;
  logic             load_use;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
  logic             pc_en;
  logic             pc_src;
  logic [WIDTH-1:0] target_pc;
  logic             trigger;
  logic             stall_fd;
  logic             flush_fd;
  logic             flush_de;
  logic             misalign_err;
  logic [1:0]       fsm_state;
  logic [31:0]      stall_count;

  modport slave (
    input  start, halt, imem_ready, load_use, redirect, redirect_pc,
    output pc_en, pc_src, target_pc, trigger, stall_fd, flush_fd, flush_de,
           misalign_err, fsm_state, stall_count
  );

  modport master (
    output start, halt, imem_ready, load_use, redirect, redirect_pc,
    input  pc_en, pc_src, target_pc, trigger, stall_fd, flush_fd, flush_de,
           misalign_err, fsm_state, stall_count
  );
endinterface

// File: rtl/pc_ctrl.sv
// Program-counter / pipeline hazard controller: IDLE, RUN, STALL and REDIRECT states.
// Optional stalled-cycle counter enabled by defining PC_CTRL_PERF_EN.
module pc_ctrl #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  pc_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RUN      = 2'b01,
    STALL    = 2'b10,
    REDIRECT = 2'b11
  } state_e;

  state_e state_r;
  state_e next_state_s;
  logic   pc_en_s;
  logic   pc_src_s;
  logic   stall_fd_s;
  logic   flush_fd_s;
  logic   flush_de_s;
  logic   redirect_taken_s;
  logic   trigger_r;
  logic   misalign_r;

  // Next-state and zero-latency pipeline controls; reset forces IDLE outputs.
  always_comb begin
    next_state_s     = state_r;
    pc_en_s          = 1'b0;
    pc_src_s         = 1'b0;
    stall_fd_s       = 1'b0;
    flush_fd_s       = 1'b0;
    flush_de_s       = 1'b0;
    redirect_taken_s = 1'b0;
    if (rst) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start && !bus.halt) begin
            next_state_s = RUN;
          end else begin
            next_state_s = IDLE;
          end
        end
        RUN, STALL, REDIRECT: begin
          if (bus.halt) begin
            flush_fd_s   = 1'b1;
            flush_de_s   = 1'b1;
            next_state_s = IDLE;
          end else if (bus.redirect) begin
            // Branch target wins even when memory is busy: the stale fetch is flushed.
            pc_src_s         = 1'b1;
            pc_en_s          = 1'b1;
            flush_fd_s       = 1'b1;
            flush_de_s       = 1'b1;
            redirect_taken_s = 1'b1;
            next_state_s     = REDIRECT;
          end else if (bus.load_use && (state_r != STALL)) begin
            stall_fd_s   = 1'b1;
            flush_de_s   = 1'b1;
            next_state_s = STALL;
          end else begin
            pc_en_s      = bus.imem_ready;
            flush_fd_s   = (state_r == REDIRECT);
            next_state_s = RUN;
          end
        end
        default: begin
          next_state_s = IDLE;
        end
      endcase
    end
  end

  // State register, delayed run gate and sticky misalignment flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      trigger_r  <= 1'b0;
      misalign_r <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      trigger_r  <= (state_r != IDLE);
      misalign_r <= misalign_r | (redirect_taken_s && (bus.redirect_pc[1:0] != 2'b00));
    end
  end

`ifdef PC_CTRL_PERF_EN
  logic [31:0] stall_count_r;

  // Saturating count of active cycles in which the PC did not advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_r <= 32'd0;
    end else if ((state_r != IDLE) && !pc_en_s && (stall_count_r != 32'hFFFF_FFFF)) begin
      stall_count_r <= stall_count_r + 32'd1;
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign bus.stall_count = stall_count_r;
`else
  assign bus.stall_count = 32'd0;
`endif

  assign bus.pc_en        = pc_en_s;
  assign bus.pc_src       = pc_src_s;
  assign bus.stall_fd     = stall_fd_s;
  assign bus.flush_fd     = flush_fd_s;
  assign bus.flush_de     = flush_de_s;
  assign bus.target_pc    = {bus.redirect_pc[WIDTH-1:2], 2'b00};
  assign bus.trigger      = trigger_r;
  assign bus.misalign_err = misalign_r;
  assign bus.fsm_state    = state_r;
endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: directed scenarios then randomized traffic, checked
// against a rule-level reference model; honours PC_CTRL_PERF_EN for stall_count.
module tb_pc_ctrl;
  logic clk;
  logic rst;

  pc_ctrl_if #(.WIDTH(32)) bus ();

  pc_ctrl #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          regs_known;
    logic [1:0]  st;
    logic        trig;
    logic        mis;
    logic [31:0] cnt;
    logic        pc_en;
    logic        pc_src;
    logic        stall_fd;
    logic        flush_fd;
    logic        flush_de;
    logic [31:0] tpc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int popped = 0;

  // Reference model state: mode 0 idle, 1 run, 2 stall, 3 redirect.
  int          m_mode = 0;
  bit          m_known = 1'b0;
  logic        m_trig = 1'b0;
  logic        m_mis = 1'b0;
  logic [31:0] m_cnt = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive inputs, predict this cycle, advance the model.
  task automatic step(input bit r, input bit st, input bit h, input bit ir,
                      input bit lu, input bit rd, input logic [31:0] rpc);
    exp_t e;
    bit active;
    bit moved;
    @(posedge clk);
    #1;
    rst = r; bus.start = st; bus.halt = h; bus.imem_ready = ir;
    bus.load_use = lu; bus.redirect = rd; bus.redirect_pc = rpc;

    active = !r && (m_mode != 0);
    e.regs_known = m_known;
    e.st   = 2'(m_mode);
    e.trig = m_trig;
    e.mis  = m_mis;
    e.cnt  = m_cnt;
    e.tpc  = rpc & 32'hFFFF_FFFC;
    e.pc_en = 1'b0; e.pc_src = 1'b0; e.stall_fd = 1'b0; e.flush_fd = 1'b0; e.flush_de = 1'b0;
    if (active && h) begin
      e.flush_fd = 1'b1; e.flush_de = 1'b1;
    end else if (active && rd) begin
      e.pc_src = 1'b1; e.pc_en = 1'b1; e.flush_fd = 1'b1; e.flush_de = 1'b1;
    end else if (active && lu && m_mode != 2) begin
      e.stall_fd = 1'b1; e.flush_de = 1'b1;
    end else if (active) begin
      e.pc_en = ir;
      e.flush_fd = (m_mode == 3);
    end
    sb.push_back(e);
    pushed++;

    if (r) begin
      m_mode = 0; m_trig = 1'b0; m_mis = 1'b0; m_cnt = 32'd0; m_known = 1'b1;
    end else begin
      m_trig = (m_mode != 0);
`ifdef PC_CTRL_PERF_EN
      if (active && !e.pc_en && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
`endif
      if (active && !h && rd && rpc[1:0] != 2'b00) m_mis = 1'b1;
      moved = 1'b0;
      if (m_mode == 0) begin
        if (st && !h) m_mode = 1;
      end else if (h) m_mode = 0;
      else if (rd) m_mode = 3;
      else if (lu && m_mode != 2) m_mode = 2;
      else m_mode = 1;
    end
  endtask

  // Monitor: the DUT presents a full output set every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        popped++;
        chk("pc_en", {31'd0, bus.pc_en}, {31'd0, e.pc_en});
        chk("pc_src", {31'd0, bus.pc_src}, {31'd0, e.pc_src});
        chk("stall_fd", {31'd0, bus.stall_fd}, {31'd0, e.stall_fd});
        chk("flush_fd", {31'd0, bus.flush_fd}, {31'd0, e.flush_fd});
        chk("flush_de", {31'd0, bus.flush_de}, {31'd0, e.flush_de});
        chk("target_pc", bus.target_pc, e.tpc);
        if (e.regs_known) begin
          chk("fsm_state", {30'd0, bus.fsm_state}, {30'd0, e.st});
          chk("trigger", {31'd0, bus.trigger}, {31'd0, e.trig});
          chk("misalign_err", {31'd0, bus.misalign_err}, {31'd0, e.mis});
          chk("stall_count", bus.stall_count, e.cnt);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.halt = 1'b0; bus.imem_ready = 1'b0;
    bus.load_use = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'd0;

    // Reset, start, load-use pair, redirect with misaligned target, halt in REDIRECT.
    step(1, 0, 0, 0, 0, 0, 32'd0);
    step(1, 0, 0, 0, 0, 0, 32'd0);
    step(0, 1, 0, 1, 0, 0, 32'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, 0, 32'd0);
    step(0, 0, 0, 1, 1, 0, 32'd0);
    step(0, 0, 0, 1, 1, 0, 32'd0);
    step(0, 0, 0, 1, 0, 0, 32'd0);
    step(0, 0, 0, 1, 1, 1, 32'h0000_0102);
    step(0, 0, 1, 1, 0, 1, 32'h0000_0200);
    step(0, 0, 0, 1, 0, 0, 32'd0);
    step(0, 0, 0, 1, 0, 0, 32'd0);
    // Memory busy for five RUN cycles, then reset in the middle of STALL.
    step(0, 1, 0, 0, 0, 0, 32'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 32'd0);
    step(0, 0, 0, 1, 0, 0, 32'd0);
    step(0, 0, 0, 1, 1, 0, 32'd0);
    step(1, 0, 0, 1, 0, 0, 32'd0);
    step(0, 0, 0, 1, 0, 0, 32'd0);
    // Reset in the middle of REDIRECT.
    step(0, 1, 0, 1, 0, 0, 32'd0);
    step(0, 0, 0, 1, 0, 1, 32'h0000_1001);
    step(1, 0, 0, 1, 0, 0, 32'd0);
    step(0, 0, 0, 1, 0, 0, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0),
           $urandom);
    end

    @(posedge clk);
    @(posedge clk);
    chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    chk("scoreboard_count", 32'(popped), 32'(pushed));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
